// File: rtl/stream_sum_sink.sv
// Stream sink: takes a job length, reduces that many beats to a sum.
// Define SUM_SIGNED_EN to treat stream data as two's complement.
module stream_sum_sink #(
    parameter int N     = 8,
    parameter int LEN_W = 8,
    parameter int SUM_W = N + LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] in_len,
    input  logic [N-1:0]     sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_n;
    logic [SUM_W-1:0] ext_in;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_n;

`ifdef SUM_SIGNED_EN
    assign ext_in = SUM_W'($signed(sIn));
`else
    assign ext_in = SUM_W'(sIn);
`endif

    // Handshakes come from state only; rst just masks in_ready.
    assign in_ready  = (state == IDLE) && !rst;
    assign sIn_ready = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = cnt;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        len_n   = len_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    len_n   = in_len;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = (in_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (sIn_valid) begin
                    acc_n = acc + ext_in;
                    cnt_n = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1))
                        state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            len_q <= len_n;
        end
    end

endmodule

// File: tb/tb_stream_sum_sink.sv
// Randomized and directed bench for stream_sum_sink.
// Expected sums come from integer arithmetic over the beat list.
module tb_stream_sum_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_len;
    logic [7:0]  sIn;
    logic        sIn_valid;
    logic        sIn_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] beats [256];

    stream_sum_sink dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_len(in_len),
        .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_sum(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) begin
`ifdef SUM_SIGNED_EN
            s += (beats[i] > 8'd127) ? int'(beats[i]) - 256 : int'(beats[i]);
`else
            s += int'(beats[i]);
`endif
        end
        return s[15:0];
    endfunction

    task automatic run_job(input int len, input int gap_pct, input int bp);
        int i = 0;
        int guard = 0;
        logic [15:0] exp = ref_sum(len);
        while (!in_ready && guard < 1000) begin
            step();
            guard++;
        end
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_len   = len[7:0];
        step();
        in_valid = 1'b0;
        in_len   = 8'hxx;
        if (len == 0) begin
            chk("zero_sready", sIn_ready, 0);
        end else begin
            guard = 0;
            while (i < len && guard < 4000) begin
                sIn_valid = ($urandom_range(99) >= gap_pct);
                sIn       = beats[i];
                chk("acc_sready", sIn_ready, 1);
                chk("acc_inready", in_ready, 0);
                chk("acc_oval", out_valid, 0);
                step();
                if (sIn_valid) i++;
                guard++;
            end
            chk("beat_timeout", i, len);
            sIn_valid = 1'b0;
            sIn       = $urandom();
        end
        chk("oval_lat", out_valid, 1);
        for (int k = 0; k < bp; k++) begin
            chk("bp_oval", out_valid, 1);
            chk("bp_sum", out_sum, exp);
            chk("bp_cnt", out_count, len);
            chk("bp_inready", in_ready, 0);
            chk("bp_sready", sIn_ready, 0);
            step();
        end
        chk("sum", out_sum, exp);
        chk("count", out_count, len);
        chk("done_inready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_oval", out_valid, 0);
        chk("post_inready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_len = '0;
        sIn = '0;
        sIn_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_inready", in_ready, 0);
        chk("rst_sready", sIn_ready, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cnt", out_count, 0);
        rst = 1'b0;
        #1;
        chk("rel_inready", in_ready, 1);

        for (int k = 0; k < 4; k++) beats[k] = 8'(k + 1);
        run_job(4, 0, 0);
        chk("t1_sum", out_sum, ref_sum(4));

        run_job(0, 0, 1);

        beats[0] = 8'd7; beats[1] = 8'd0; beats[2] = 8'd9;
        run_job(3, 50, 3);

        for (int k = 0; k < 255; k++) beats[k] = 8'hFF;
        run_job(255, 0, 1);

        for (int k = 0; k < 5; k++) beats[k] = 8'(20 + k);
        in_valid = 1'b1;
        in_len   = 8'd5;
        step();
        in_valid  = 1'b0;
        sIn_valid = 1'b1;
        sIn       = beats[0];
        step();
        sIn = beats[1];
        step();
        chk("mid_cnt", out_count, 2);
        rst = 1'b1;
        sIn_valid = 1'b0;
        #1;
        chk("mid_rst_inready", in_ready, 0);
        step();
        chk("mid_rst_sready", sIn_ready, 0);
        chk("mid_rst_oval", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_cnt", out_count, 0);
        rst = 1'b0;
        beats[0] = 8'd5; beats[1] = 8'd6;
        run_job(2, 0, 0);

        beats[0] = 8'hFF; beats[1] = 8'h01;
        run_job(2, 0, 0);

        for (int j = 0; j < 20; j++) begin
            int len = $urandom_range(12);
            for (int k = 0; k < len; k++) beats[k] = 8'($urandom());
            run_job(len, $urandom_range(60), $urandom_range(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
